program_counter: RTL and testbench

PROGRAM_COUNTER -- requirements
Module: program_counter

---
 rtl/program_counter_pkg.sv | 20 ++
 rtl/program_counter_if.sv | 23 ++
 rtl/program_counter_next_sel.sv | 40 ++++
 rtl/program_counter.sv | 31 +++
 tb/tb_program_counter.sv | 131 +++++++++++++
 5 files changed

// File: rtl/program_counter_pkg.sv
// Shared constants and types for the program counter and its next-value selector.
package program_counter_pkg;

  localparam int unsigned PC_WIDTH     = 32;
  localparam logic [31:0] PC_RESET     = 32'h0;
  localparam int unsigned PC_STEP      = 4;
  localparam int unsigned BRANCH_SHIFT = 2;

  typedef logic [PC_WIDTH-1:0] pc_t;

  // Source of the next PC value, in descending priority below reset.
  typedef enum logic [2:0] {
    SEL_FREEZE,
    SEL_LOAD,
    SEL_BRANCH,
    SEL_INC,
    SEL_HOLD
  } pc_sel_e;

endpackage

// File: rtl/program_counter_if.sv
// Control, operand and PC-value bundle between the fetch controller and the program counter.
interface program_counter_if;
  import program_counter_pkg::*;

  logic load;
  logic inc;
  logic ALU_out;
  logic Disable;
  pc_t  data;
  pc_t  imm_val;
  pc_t  pc_val;

  modport master (
    output load, inc, ALU_out, Disable, data, imm_val,
    input  pc_val
  );

  modport slave (
    input  load, inc, ALU_out, Disable, data, imm_val,
    output pc_val
  );

endinterface

// File: rtl/program_counter_next_sel.sv
// Purely combinational next-PC selector: freeze, absolute jump, relative branch, step or hold.
module pc_next_sel
  import program_counter_pkg::*;
(
  input  pc_t  pc_i,
  input  logic disable_i,
  input  logic load_i,
  input  logic alu_out_i,
  input  logic inc_i,
  input  pc_t  data_i,
  input  pc_t  imm_val_i,
  output pc_t  pc_next_o
);

  pc_sel_e sel;
  pc_t     branch_off;

  // Word offset to byte offset; the top BRANCH_SHIFT bits of imm_val fall off.
  assign branch_off = PC_WIDTH'(imm_val_i << BRANCH_SHIFT);

  always_comb begin
    sel = SEL_HOLD;
    if (disable_i)      sel = SEL_FREEZE;
    else if (load_i)    sel = SEL_LOAD;
    else if (alu_out_i) sel = SEL_BRANCH;
    else if (inc_i)     sel = SEL_INC;
  end

  // All sums wrap modulo 2^PC_WIDTH.
  always_comb begin
    pc_next_o = pc_i;
    case (sel)
      SEL_LOAD:   pc_next_o = data_i + PC_WIDTH'(PC_STEP);
      SEL_BRANCH: pc_next_o = pc_i + branch_off;
      SEL_INC:    pc_next_o = pc_i + PC_WIDTH'(PC_STEP);
      default:    pc_next_o = pc_i;
    endcase
  end

endmodule

// File: rtl/program_counter.sv
// Program counter register; clr clears it synchronously, otherwise it takes the selected next value.
module program_counter
  import program_counter_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  program_counter_if.slave  bus
);

  pc_t pc_q;
  pc_t pc_d;

  pc_next_sel u_next_sel (
    .pc_i      (pc_q),
    .disable_i (bus.Disable),
    .load_i    (bus.load),
    .alu_out_i (bus.ALU_out),
    .inc_i     (bus.inc),
    .data_i    (bus.data),
    .imm_val_i (bus.imm_val),
    .pc_next_o (pc_d)
  );

  always_ff @(posedge clk) begin
    if (clr) pc_q <= PC_RESET;
    else     pc_q <= pc_d;
  end

  assign bus.pc_val = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed and randomized checks of program_counter against an arithmetic reference model.
module tb_program_counter;

  logic clk = 1'b0;
  logic clr;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] exp_pc;

  program_counter_if bus ();

  program_counter dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: priority rules evaluated with wide integers, then reduced mod 2^32.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic c, input logic dis,
                                           input logic ld, input logic br, input logic in,
                                           input logic [31:0] dt, input logic [31:0] im);
    longint unsigned r;
    if (c)        r = 0;
    else if (dis) r = longint'(pc);
    else if (ld)  r = longint'(dt) + 4;
    else if (br)  r = longint'(pc) + longint'(im) * 4;
    else if (in)  r = longint'(pc) + 4;
    else          r = longint'(pc);
    return 32'(r % 64'h1_0000_0000);
  endfunction

  task automatic step(input logic c, input logic dis, input logic ld, input logic br,
                      input logic in, input logic [31:0] dt, input logic [31:0] im);
    @(negedge clk);
    clr = c; bus.Disable = dis; bus.load = ld; bus.ALU_out = br; bus.inc = in;
    bus.data = dt; bus.imm_val = im;
    @(posedge clk);
    #1;
    exp_pc = ref_next(exp_pc, c, dis, ld, br, in, dt, im);
  endtask

  initial begin
    clr = 1'b0; bus.Disable = 1'b0; bus.load = 1'b0; bus.ALU_out = 1'b0; bus.inc = 1'b0;
    bus.data = '0; bus.imm_val = '0;
    exp_pc = '0;

    step(1, 0, 0, 0, 0, 0, 0);
    check_eq("reset_1", bus.pc_val, 32'h0);
    step(1, 0, 0, 1, 1, 32'h55, 32'h7);
    check_eq("reset_2", bus.pc_val, 32'h0);
    step(0, 0, 0, 0, 1, 0, 0);
    check_eq("inc_1", bus.pc_val, 32'h4);
    step(0, 0, 0, 0, 1, 0, 0);
    check_eq("inc_2", bus.pc_val, 32'h8);

    // clr raised between edges must not act until the next rising edge.
    @(negedge clk);
    clr = 1'b1; bus.inc = 1'b0;
    #2;
    check_eq("clr_sync_wait", bus.pc_val, 32'h8);
    step(1, 0, 0, 0, 0, 0, 0);
    check_eq("clr_from_8", bus.pc_val, 32'h0);

    step(0, 0, 1, 0, 1, 32'd20, 0);
    check_eq("load_20", bus.pc_val, 32'd24);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 1, 1, 1, 32'h0, 32'h3);
      check_eq("disable_hold", bus.pc_val, 32'd24);
    end
    step(0, 0, 0, 0, 0, 32'hdead_beef, 32'h1234);
    check_eq("idle_hold", bus.pc_val, 32'd24);

    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h40, 32'd2);
    check_eq("branch_imm2", bus.pc_val, 32'd8);

    step(0, 0, 1, 0, 0, 32'hFC, 0);
    check_eq("load_to_100", bus.pc_val, 32'h100);
    step(0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF);
    check_eq("branch_back", bus.pc_val, 32'hFC);
    step(0, 0, 0, 1, 0, 0, 32'hC000_0001);
    check_eq("branch_trunc", bus.pc_val, 32'h100);

    step(0, 0, 1, 0, 0, 32'hFFFF_FFF8, 0);
    check_eq("load_to_top", bus.pc_val, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1, 0, 0);
    check_eq("inc_wrap", bus.pc_val, 32'h0);
    step(0, 0, 1, 0, 0, 32'hFFFF_FFFC, 0);
    check_eq("load_wrap", bus.pc_val, 32'h0);

    step(0, 0, 1, 0, 0, 32'h1000, 0);
    step(1, 0, 1, 1, 1, 32'h2000, 32'h5);
    check_eq("clr_over_load", bus.pc_val, 32'h0);
    step(0, 0, 0, 0, 1, 0, 0);
    check_eq("after_clr_inc", bus.pc_val, 32'h4);

    for (int k = 0; k < 400; k++) begin
      logic c, dis, ld, br, in;
      logic [31:0] dt, im;
      c   = ($urandom_range(0, 19) == 0);
      dis = ($urandom_range(0, 5) == 0);
      ld  = ($urandom_range(0, 4) == 0);
      br  = ($urandom_range(0, 3) == 0);
      in  = ($urandom_range(0, 1) == 0);
      dt  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      im  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
      step(c, dis, ld, br, in, dt, im);
      check_eq("random", bus.pc_val, exp_pc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
